// File: rtl/usb_tx_sched_if.sv
// Bus bundle between the three frame sources, the downstream TX FIFO and
// the usb_tx_sched scheduler. The scheduler connects through the slave modport.
interface usb_tx_sched_if #(
  parameter int DW = 16,
  parameter int LW = 8
);
  logic          ccw_req;
  logic          dat_req;
  logic          sts_req;
  logic [LW-1:0] ccw_len;
  logic [LW-1:0] dat_len;
  logic [LW-1:0] sts_len;
  logic [DW-1:0] ccw_data;
  logic [DW-1:0] dat_data;
  logic [DW-1:0] sts_data;
  logic [2:0]    src_rdreq;
  logic [2:0]    grant;
  logic          tx_full;
  logic          tx_wrreq;
  logic [DW-1:0] tx_data;
  logic          frame_done;
  logic [1:0]    frame_src;
  logic          tmo_err;
  logic          ccw_repeat_req;

  modport master (
    output ccw_req, dat_req, sts_req,
    output ccw_len, dat_len, sts_len,
    output ccw_data, dat_data, sts_data,
    output tx_full,
    input  src_rdreq, grant, tx_wrreq, tx_data,
    input  frame_done, frame_src, tmo_err, ccw_repeat_req
  );

  modport slave (
    input  ccw_req, dat_req, sts_req,
    input  ccw_len, dat_len, sts_len,
    input  ccw_data, dat_data, sts_data,
    input  tx_full,
    output src_rdreq, grant, tx_wrreq, tx_data,
    output frame_done, frame_src, tmo_err, ccw_repeat_req
  );
endinterface

// File: rtl/usb_tx_sched.sv
// USB TX frame scheduler: arbitrates three frame sources (ccw has strict
// priority, dat/sts round-robin), streams the granted frame into the FTDI TX
// FIFO, aborts on a prolonged FIFO-full condition and inserts an idle gap.
module usb_tx_sched #(
  parameter int DW      = 16,
  parameter int LW      = 8,
  parameter int GAP_CYC = 4,
  parameter int TMO_CYC = 1024
) (
  input  logic clk_prj,
  input  logic n_rst,
  usb_tx_sched_if.slave bus
);
  localparam int CW = LW + 1;
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_XFER = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_owner;        // 0 ccw, 1 dat, 2 sts
  logic [CW-1:0] r_cnt;          // words still to be read
  logic [TW-1:0] r_tmo;          // consecutive full cycles in XFER
  logic [GW-1:0] r_gap;          // remaining gap cycles
  logic          r_rr_sts;       // 1: sts wins the next dat/sts tie
  logic [2:0]    r_grant;
  logic          r_wrreq;
  logic [1:0]    r_wr_src;
  logic          r_frame_done;
  logic [1:0]    r_frame_src;
  logic          r_tmo_err;
  logic          r_ccw_rep;

  logic          w_any_req;
  logic          w_have_win;
  logic [1:0]    w_win;
  logic [LW-1:0] w_win_len_raw;
  logic [CW-1:0] w_win_len;
  logic          w_rd;
  logic          w_done;
  logic          w_tmo_hit;
  logic          w_gap_end;
  logic [2:0]    w_src_rdreq;
  logic [DW-1:0] w_tx_data;

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] v;
    case (idx)
      2'd0:    v = 3'b001;
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  assign w_any_req = bus.ccw_req | bus.dat_req | bus.sts_req;
  // A read is issued whenever the FIFO has room and words remain in the frame.
  assign w_rd      = (r_state == S_XFER) && !bus.tx_full && (r_cnt != {CW{1'b0}});
  // Counter at zero in XFER means the last read happened and its write is in flight now.
  assign w_done    = (r_state == S_XFER) && (r_cnt == {CW{1'b0}});
  assign w_tmo_hit = (r_state == S_XFER) && (r_cnt != {CW{1'b0}}) && bus.tx_full &&
                     (r_tmo == TW'(TMO_CYC - 1));
  assign w_gap_end = (r_state == S_GAP) && (r_gap == {GW{1'b0}});

  // Arbitration: ccw first, otherwise dat/sts by round-robin pointer; length 0 means 2^LW.
  always_comb begin
    w_have_win    = 1'b1;
    w_win         = 2'd0;
    w_win_len_raw = {LW{1'b0}};
    if (bus.ccw_req) begin
      w_win = 2'd0;
    end else if (bus.dat_req && (!bus.sts_req || !r_rr_sts)) begin
      w_win = 2'd1;
    end else if (bus.sts_req) begin
      w_win = 2'd2;
    end else begin
      w_have_win = 1'b0;
    end
    case (w_win)
      2'd0:    w_win_len_raw = bus.ccw_len;
      2'd1:    w_win_len_raw = bus.dat_len;
      default: w_win_len_raw = bus.sts_len;
    endcase
    w_win_len = (w_win_len_raw == {LW{1'b0}}) ? {1'b1, {LW{1'b0}}} : {1'b0, w_win_len_raw};
  end

  // FSM state register.
  always_ff @(posedge clk_prj or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = w_any_req ? S_ARB : S_IDLE;
      S_ARB:   w_state_nxt = w_have_win ? S_XFER : S_IDLE;
      S_XFER:  w_state_nxt = (w_done || w_tmo_hit) ? S_GAP : S_XFER;
      S_GAP:   w_state_nxt = w_gap_end ? S_IDLE : S_GAP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: read strobe must react to tx_full in the same cycle, so it stays combinational.
  always_comb begin
    w_src_rdreq = 3'b000;
    w_tx_data   = {DW{1'b0}};
    if (w_rd) begin
      w_src_rdreq = onehot3(r_owner);
    end else begin
      w_src_rdreq = 3'b000;
    end
    if (r_wrreq) begin
      case (r_wr_src)
        2'd0:    w_tx_data = bus.ccw_data;
        2'd1:    w_tx_data = bus.dat_data;
        default: w_tx_data = bus.sts_data;
      endcase
    end else begin
      w_tx_data = {DW{1'b0}};
    end
  end

  // Datapath: owner/counters, round-robin pointer and registered status outputs.
  always_ff @(posedge clk_prj or negedge n_rst) begin
    if (!n_rst) begin
      r_owner      <= 2'd0;
      r_cnt        <= {CW{1'b0}};
      r_tmo        <= {TW{1'b0}};
      r_gap        <= {GW{1'b0}};
      r_rr_sts     <= 1'b0;
      r_grant      <= 3'b000;
      r_wrreq      <= 1'b0;
      r_wr_src     <= 2'd0;
      r_frame_done <= 1'b0;
      r_frame_src  <= 2'd0;
      r_tmo_err    <= 1'b0;
      r_ccw_rep    <= 1'b0;
    end else begin
      r_wrreq      <= w_rd;
      r_wr_src     <= r_owner;
      r_frame_done <= w_done;
      r_frame_src  <= w_done ? r_owner : 2'd0;
      r_tmo_err    <= w_tmo_hit;
      r_ccw_rep    <= w_tmo_hit && (r_owner == 2'd0);

      if ((r_state == S_XFER) && bus.tx_full && !w_tmo_hit) begin
        r_tmo <= r_tmo + TW'(1);
      end else begin
        r_tmo <= {TW{1'b0}};
      end

      if ((r_state == S_ARB) && w_have_win) begin
        r_owner <= w_win;
        r_cnt   <= w_win_len;
        r_grant <= onehot3(w_win);
        if (w_win == 2'd1) begin
          r_rr_sts <= 1'b1;
        end else if (w_win == 2'd2) begin
          r_rr_sts <= 1'b0;
        end else begin
          r_rr_sts <= r_rr_sts;
        end
      end else if (w_done || w_tmo_hit) begin
        r_cnt   <= {CW{1'b0}};
        r_grant <= 3'b000;
      end else if (w_rd) begin
        r_cnt <= r_cnt - CW'(1);
      end else begin
        r_cnt <= r_cnt;
      end

      if (w_done || w_tmo_hit) begin
        r_gap <= GW'(GAP_CYC - 1);
      end else if ((r_state == S_GAP) && (r_gap != {GW{1'b0}})) begin
        r_gap <= r_gap - GW'(1);
      end else begin
        r_gap <= r_gap;
      end
    end
  end

  assign bus.src_rdreq      = w_src_rdreq;
  assign bus.grant          = r_grant;
  assign bus.tx_wrreq       = r_wrreq;
  assign bus.tx_data        = w_tx_data;
  assign bus.frame_done     = r_frame_done;
  assign bus.frame_src      = r_frame_src;
  assign bus.tmo_err        = r_tmo_err;
  assign bus.ccw_repeat_req = r_ccw_rep;
endmodule

// File: tb/tb_usb_tx_sched.sv
// Directed bench for usb_tx_sched: counting source models, a per-cycle
// monitor for strobe/data rules, and hand-computed expectations per scenario.
module tb_usb_tx_sched;
  localparam int DW = 16;
  localparam int LW = 8;
  localparam int GAP_CYC = 4;
  localparam int TMO_CYC = 1024;

  logic clk_prj = 1'b0;
  logic n_rst   = 1'b0;
  always #5 clk_prj = ~clk_prj;

  usb_tx_sched_if #(.DW(DW), .LW(LW)) bus ();

  usb_tx_sched #(.DW(DW), .LW(LW), .GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)) dut (
    .clk_prj (clk_prj),
    .n_rst   (n_rst),
    .bus     (bus)
  );

  // Source models: each read strobe advances that source's data word.
  logic [DW-1:0] m_ccw = 16'h1000;
  logic [DW-1:0] m_dat = 16'h2000;
  logic [DW-1:0] m_sts = 16'h3000;
  always @(posedge clk_prj) begin
    if (bus.src_rdreq[0]) m_ccw <= m_ccw + 16'd1;
    if (bus.src_rdreq[1]) m_dat <= m_dat + 16'd1;
    if (bus.src_rdreq[2]) m_sts <= m_sts + 16'd1;
  end
  assign bus.ccw_data = m_ccw;
  assign bus.dat_data = m_dat;
  assign bus.sts_data = m_sts;

  int n_vec = 0;
  int n_miss = 0;
  int rd_seen [3] = '{0, 0, 0};
  int wr_tot = 0, fd_tot = 0, tmo_tot = 0, rep_tot = 0, gnt_cyc = 0, mon_err = 0;
  logic [2:0] prev_rd = 3'b000;
  logic [2:0] s_rd, s_gnt;
  logic       s_wr, s_fd, s_tmo;
  logic [1:0] s_src;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, update the monitor, return just after the rising edge.
  task automatic step();
    logic [DW-1:0] w_exp;
    @(negedge clk_prj);
    s_rd = bus.src_rdreq; s_wr = bus.tx_wrreq; s_gnt = bus.grant;
    s_fd = bus.frame_done; s_src = bus.frame_src; s_tmo = bus.tmo_err;
    if (!n_rst) prev_rd = 3'b000;
    w_exp = 16'h0000;
    if (bus.tx_wrreq) begin
      wr_tot++;
      case (prev_rd)
        3'b001:  w_exp = 16'h1000 + DW'(rd_seen[0]);
        3'b010:  w_exp = 16'h2000 + DW'(rd_seen[1]);
        3'b100:  w_exp = 16'h3000 + DW'(rd_seen[2]);
        default: mon_err++;
      endcase
      if (bus.tx_data !== w_exp) mon_err++;
    end else if (prev_rd != 3'b000) begin
      mon_err++;
    end
    if (bus.src_rdreq != 3'b000) begin
      if ($countones(bus.src_rdreq) != 1) mon_err++;
      if (bus.tx_full) mon_err++;
      if (bus.src_rdreq != bus.grant) mon_err++;
    end
    if ($countones(bus.grant) > 1) mon_err++;
    for (int i = 0; i < 3; i++) if (bus.src_rdreq[i]) rd_seen[i]++;
    prev_rd = bus.src_rdreq;
    if (bus.frame_done) fd_tot++;
    if (bus.tmo_err) tmo_tot++;
    if (bus.ccw_repeat_req) rep_tot++;
    if (bus.grant != 3'b000) gnt_cyc++;
    @(posedge clk_prj);
    #1;
  endtask

  // Step until frame_done (dropping the request once granted); expired budget is a failure.
  task automatic run_frame(input string tag, input int budget, output logic [1:0] src);
    logic got;
    got = 1'b0;
    src = 2'd3;
    for (int c = 0; c < budget && !got; c++) begin
      step();
      if (s_gnt[0]) bus.ccw_req = 1'b0;
      if (s_gnt[1]) bus.dat_req = 1'b0;
      if (s_gnt[2]) bus.sts_req = 1'b0;
      if (s_fd) begin got = 1'b1; src = s_src; end
    end
    chk({tag, "_done"}, 32'(got), 32'd1);
  endtask

  logic [11:0] v_rd, v_wr, v_gnt, v_fd;
  logic [1:0]  src_at_fd, f_src;
  logic [1:0]  order [5];
  int nf, b_rd0, b_rd1, b_rd2, b_wr, b_fd, b_tmo, b_rep;
  logic tmo_seen;

  initial begin
    bus.ccw_req = 1'b0; bus.dat_req = 1'b0; bus.sts_req = 1'b0;
    bus.ccw_len = 8'd0; bus.dat_len = 8'd0; bus.sts_len = 8'd0;
    bus.tx_full = 1'b0;

    // Reset state
    step(); step();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_rdreq", 32'(bus.src_rdreq), 32'd0);
    chk("rst_wrreq", 32'(bus.tx_wrreq), 32'd0);
    chk("rst_fdone", 32'(bus.frame_done), 32'd0);
    chk("rst_tmo",   32'({bus.tmo_err, bus.ccw_repeat_req}), 32'd0);
    n_rst = 1'b1;
    step(); step();

    // Single ccw frame of 3 words, cycle-exact; request dropped mid-frame
    bus.ccw_req = 1'b1; bus.ccw_len = 8'd3;
    src_at_fd = 2'd3;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) bus.ccw_req = 1'b0;
      step();
      v_rd[i] = s_rd[0]; v_wr[i] = s_wr; v_gnt[i] = (s_gnt != 3'b000); v_fd[i] = s_fd;
      if (s_fd) src_at_fd = s_src;
    end
    chk("ccw3_rdreq", 32'(v_rd),  32'h01C);
    chk("ccw3_wrreq", 32'(v_wr),  32'h038);
    chk("ccw3_grant", 32'(v_gnt), 32'h03C);
    chk("ccw3_fdone", 32'(v_fd),  32'h040);
    chk("ccw3_src",   32'(src_at_fd), 32'd0);

    // dat/sts round-robin with ccw injected during the second dat frame
    b_rd0 = rd_seen[0]; b_rd1 = rd_seen[1]; b_rd2 = rd_seen[2];
    bus.dat_req = 1'b1; bus.sts_req = 1'b1; bus.dat_len = 8'd2; bus.sts_len = 8'd2;
    bus.ccw_len = 8'd1;
    nf = 0;
    for (int c = 0; c < 200 && nf < 5; c++) begin
      step();
      if (nf == 2 && s_gnt == 3'b010) bus.ccw_req = 1'b1;
      if (s_gnt == 3'b001) bus.ccw_req = 1'b0;
      if (s_fd) begin order[nf] = s_src; nf++; end
    end
    bus.dat_req = 1'b0; bus.sts_req = 1'b0;
    chk("rr_frames", 32'(nf), 32'd5);
    if (nf == 5) begin
      chk("rr_f0", 32'(order[0]), 32'd1);
      chk("rr_f1", 32'(order[1]), 32'd2);
      chk("rr_f2", 32'(order[2]), 32'd1);
      chk("rr_f3", 32'(order[3]), 32'd0);
      chk("rr_f4", 32'(order[4]), 32'd2);
    end
    chk("rr_ccw_words", 32'(rd_seen[0] - b_rd0), 32'd1);
    chk("rr_dat_words", 32'(rd_seen[1] - b_rd1), 32'd4);
    chk("rr_sts_words", 32'(rd_seen[2] - b_rd2), 32'd4);
    for (int i = 0; i < 6; i++) step();

    // sts frame of 4 words with tx_full toggling every cycle
    b_wr = wr_tot; b_tmo = tmo_tot;
    bus.sts_req = 1'b1; bus.sts_len = 8'd4;
    f_src = 2'd3;
    begin : tgl
      logic got;
      got = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
        step();
        bus.tx_full = ~bus.tx_full;
        if (s_gnt[2]) bus.sts_req = 1'b0;
        if (s_fd) begin got = 1'b1; f_src = s_src; end
      end
      chk("tgl_done", 32'(got), 32'd1);
    end
    bus.tx_full = 1'b0;
    chk("tgl_writes", 32'(wr_tot - b_wr), 32'd4);
    chk("tgl_src", 32'(f_src), 32'd2);
    chk("tgl_no_tmo", 32'(tmo_tot - b_tmo), 32'd0);
    for (int i = 0; i < 6; i++) step();

    // dat frame with length 0 -> 256 words
    b_rd1 = rd_seen[1]; b_wr = wr_tot;
    bus.dat_req = 1'b1; bus.dat_len = 8'd0;
    run_frame("len0", 600, f_src);
    chk("len0_reads", 32'(rd_seen[1] - b_rd1), 32'd256);
    chk("len0_writes", 32'(wr_tot - b_wr), 32'd256);
    chk("len0_src", 32'(f_src), 32'd1);
    for (int i = 0; i < 6; i++) step();

    // ccw frame stalled by tx_full until timeout
    b_rd0 = rd_seen[0]; b_fd = fd_tot; b_tmo = tmo_tot; b_rep = rep_tot; gnt_cyc = 0;
    bus.ccw_req = 1'b1; bus.ccw_len = 8'd5; bus.tx_full = 1'b1;
    tmo_seen = 1'b0;
    for (int c = 0; c < 1200 && !tmo_seen; c++) begin
      step();
      if (s_gnt[0]) bus.ccw_req = 1'b0;
      if (s_tmo) tmo_seen = 1'b1;
    end
    chk("tmo_seen", 32'(tmo_seen), 32'd1);
    chk("tmo_xfer_cycles", 32'(gnt_cyc), 32'd1024);
    bus.tx_full = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("tmo_pulses", 32'(tmo_tot - b_tmo), 32'd1);
    chk("tmo_repeat", 32'(rep_tot - b_rep), 32'd1);
    chk("tmo_no_fdone", 32'(fd_tot - b_fd), 32'd0);
    chk("tmo_no_reads", 32'(rd_seen[0] - b_rd0), 32'd0);
    chk("tmo_gap_grant", 32'(gnt_cyc), 32'd1024);

    // Reset in the middle of a frame
    b_rd0 = rd_seen[0];
    bus.ccw_req = 1'b1; bus.ccw_len = 8'd8;
    for (int c = 0; c < 50 && (rd_seen[0] - b_rd0) < 3; c++) step();
    chk("mid_reads", 32'(rd_seen[0] - b_rd0), 32'd3);
    bus.ccw_req = 1'b0;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_outs", 32'({bus.grant, bus.src_rdreq, bus.tx_wrreq, bus.frame_done,
                             bus.tmo_err, bus.ccw_repeat_req}), 32'd0);
    chk("mid_rst_data", 32'(bus.tx_data), 32'd0);
    b_fd = fd_tot; b_tmo = tmo_tot; b_rep = rep_tot;
    step(); step();
    n_rst = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("mid_no_events", 32'((fd_tot - b_fd) + (tmo_tot - b_tmo) + (rep_tot - b_rep)), 32'd0);
    b_wr = wr_tot;
    bus.ccw_req = 1'b1; bus.ccw_len = 8'd3;
    run_frame("post_rst", 50, f_src);
    chk("post_rst_writes", 32'(wr_tot - b_wr), 32'd3);
    chk("post_rst_src", 32'(f_src), 32'd0);
    for (int i = 0; i < 6; i++) step();

    // Round-robin pointer returns to dat after reset (it pointed at sts before)
    bus.dat_req = 1'b1; bus.sts_req = 1'b1; bus.dat_len = 8'd1; bus.sts_len = 8'd1;
    run_frame("rr_rst", 50, f_src);
    chk("rr_rst_first", 32'(f_src), 32'd1);
    bus.dat_req = 1'b0; bus.sts_req = 1'b0;
    for (int i = 0; i < 6; i++) step();

    chk("monitor_rules", 32'(mon_err), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/usb_tx_sched.md
USB_TX_SCHED -- requirements
Module: usb_tx_sched

Interface
REQ-001 SHALL have parameter DW, 16, data word width.
REQ-002 SHALL have parameter LW, 8, frame length field width.
REQ-003 SHALL have parameter GAP_CYC, 4, idle cycles inserted between frames (minimum 1).
REQ-004 SHALL have parameter TMO_CYC, 1024, consecutive tx_full cycles in XFER before abort.
REQ-005 SHALL have port clk_prj  in  1  project clock; all logic is single-domain on it.
REQ-006 SHALL have port n_rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports ccw_req / dat_req / sts_req  in  1 each  source i has a frame pending (level).
REQ-008 SHALL have ports ccw_len / dat_len / sts_len  in  LW each  frame length in words; 0 means 2^LW.
REQ-009 SHALL have ports ccw_data / dat_data / sts_data  in  DW each  source read data, valid 1 cycle after the matching rdreq.
REQ-010 SHALL have port src_rdreq  out  3  per-source read strobe; bit0 ccw, bit1 dat, bit2 sts.
REQ-011 SHALL have port grant  out  3  one-hot owner of current frame, 0 when none.
REQ-012 SHALL have port tx_full  in  1  downstream FTDI TX FIFO almost-full (at least 1 free slot guaranteed).
REQ-013 SHALL have ports tx_wrreq  out  1 and tx_data  out  DW  write to the downstream FIFO.
REQ-014 SHALL have ports frame_done  out  1 (pulse) and frame_src  out  2  (0 ccw, 1 dat, 2 sts, valid with frame_done).
REQ-015 SHALL have ports tmo_err  out  1 (pulse) and ccw_repeat_req  out  1 (pulse)  abort indications.

Function
REQ-016 SHALL implement FSM states IDLE, ARB, XFER, GAP.
REQ-017 IDLE -> ARB when any *_req is high; otherwise remain.
REQ-018 ARB SHALL take exactly 1 cycle: grant ccw if ccw_req; else round-robin between dat and sts, starting with dat after reset, alternating after each granted dat/sts frame; latch the winner's len into the word counter; -> XFER.
REQ-019 XFER: assert src_rdreq[owner] in every cycle where tx_full is low and words remain; never when tx_full is high.
REQ-020 tx_wrreq SHALL equal the src_rdreq OR delayed by 1 cycle; tx_data SHALL be the owner's data in that cycle (1-cycle registered latency).
REQ-021 Word counter SHALL decrement per rdreq; after the last rdreq, wait for the final tx_wrreq, then pulse frame_done with frame_src for 1 cycle and go to GAP.
REQ-022 Requests deasserting mid-frame SHALL be ignored; the frame completes at its latched length.
REQ-023 The timeout counter SHALL count consecutive XFER cycles with tx_full high, clearing on any low cycle; on reaching TMO_CYC: stop rdreq, pulse tmo_err, pulse ccw_repeat_req if owner is ccw, no frame_done, go to GAP.
REQ-024 GAP SHALL hold grant=0 and no rdreq for GAP_CYC cycles, then go to IDLE.
REQ-025 Simultaneous ccw/dat/sts requests: ccw SHALL always win; dat/sts SHALL not starve while ccw is idle.
REQ-026 grant SHALL be nonzero only in XFER; at most one bit of src_rdreq SHALL ever be set.

Reset
REQ-027 On n_rst low, immediately: FSM=IDLE, all outputs 0, counters 0, round-robin pointer = dat.
REQ-028 Reset mid-frame SHALL abandon the frame with no frame_done, tmo_err or ccw_repeat_req.

Verification
REQ-029 ccw_req=1, ccw_len=3, tx_full=0 -> ARB 1 cycle, rdreq[0] for 3 cycles, tx_wrreq for 3 cycles lagging by 1, frame_done with frame_src=0, then 4 GAP cycles.
REQ-030 dat_req=sts_req=1 held, lengths 2 -> frames alternate dat, sts, dat; ccw_req raised mid-dat frame -> ccw is next after the dat frame completes.
REQ-031 dat_len=0 -> exactly 256 rdreq/wrreq then frame_done.
REQ-032 tx_full toggled 1/0 each cycle during a 4-word frame -> 4 writes total, no rdreq while full, no timeout.
REQ-033 tx_full held high in ccw XFER for 1024 cycles -> tmo_err and ccw_repeat_req each 1-cycle pulses, no frame_done, GAP, then IDLE.
REQ-034 n_rst asserted in XFER mid-frame -> all outputs 0 at once; after release a new ccw_req receives a complete frame.
